// File: rtl/signed_bcd_conv_v_pkg.sv
// Shared definitions for the signed binary-to-BCD converter: default sizes,
// FSM state encoding and the shift-counter width helper.
package signed_bcd_conv_v_pkg;

    localparam int W_IN_DEF  = 9;
    localparam int N_DIG_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int w_in);
        return (w_in > 1) ? $clog2(w_in) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(W_IN_DEF);

endpackage

// File: rtl/signed_bcd_conv_v_if.sv
// Handshake and result bundle between the calculator, the converter and the
// seven-segment display driver.
interface signed_bcd_conv_v_if
    import signed_bcd_conv_v_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int N_DIG = N_DIG_DEF
) ();

    logic                 i_valid;
    logic                 o_ready;
    logic [W_IN-1:0]      i_fs;
    logic                 o_valid;
    logic                 o_sign;
    logic [4*N_DIG-1:0]   o_bcd;

    modport master (
        output i_valid,
        output i_fs,
        input  o_ready,
        input  o_valid,
        input  o_sign,
        input  o_bcd
    );

    modport slave (
        input  i_valid,
        input  i_fs,
        output o_ready,
        output o_valid,
        output o_sign,
        output o_bcd
    );

endinterface

// File: rtl/signed_bcd_conv_v_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_add3_v (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/signed_bcd_conv_v.sv
// Iterative signed binary-to-BCD converter: one magnitude bit per clock,
// sign and packed BCD digits registered and held until the next completion.
module signed_bcd_conv_v
    import signed_bcd_conv_v_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int N_DIG = N_DIG_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    signed_bcd_conv_v_if.slave  bus
);

    localparam int CW = cnt_width(W_IN);
    localparam int BW = 4 * N_DIG;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [W_IN-1:0]  mag_reg, mag_next;
    logic [BW-1:0]    work_reg, work_next;
    logic             sign_reg, sign_next;
    logic [BW-1:0]    bcd_reg, bcd_next;
    logic             osign_reg, osign_next;
    logic             valid_reg, valid_next;

    logic [BW-1:0]    corrected;
    logic [BW-1:0]    work_shift;
    logic [W_IN-1:0]  mag_shift;
    logic [W_IN-1:0]  mag_in;
    logic             work_unused;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_digit
            bcd_add3_v u_add3 (
                .din  (work_reg[4*gi +: 4]),
                .dout (corrected[4*gi +: 4])
            );
        end
    endgenerate

    // The bit shifted out of the top digit is always zero when 10^N_DIG > 2^(W_IN-1).
    assign {work_unused, work_shift, mag_shift} = {corrected, mag_reg, 1'b0};

    // Two's-complement magnitude; the most negative input maps to 2^(W_IN-1) unsigned.
    assign mag_in = bus.i_fs[W_IN-1] ? ((~bus.i_fs) + W_IN'(1)) : bus.i_fs;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mag_next   = mag_reg;
        work_next  = work_reg;
        sign_next  = sign_reg;
        bcd_next   = bcd_reg;
        osign_next = osign_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_valid) begin
                    sign_next  = bus.i_fs[W_IN-1];
                    mag_next   = mag_in;
                    work_next  = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                work_next = work_shift;
                mag_next  = mag_shift;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(W_IN - 1)) begin
                    bcd_next   = work_shift;
                    osign_next = sign_reg;
                    valid_next = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mag_reg   <= '0;
            work_reg  <= '0;
            sign_reg  <= 1'b0;
            bcd_reg   <= '0;
            osign_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mag_reg   <= mag_next;
            work_reg  <= work_next;
            sign_reg  <= sign_next;
            bcd_reg   <= bcd_next;
            osign_reg <= osign_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.o_ready = (state_reg == IDLE);
    assign bus.o_valid = valid_reg;
    assign bus.o_sign  = osign_reg;
    assign bus.o_bcd   = bcd_reg;

endmodule

// File: tb/tb_signed_bcd_conv_v.sv
// Directed and random checks of the signed BCD converter against a decimal
// arithmetic reference model.
module tb_signed_bcd_conv_v;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    logic        last_s;
    logic [11:0] last_b;
    realtime     t_first;
    realtime     t_second;

    always #5 clk = ~clk;

    signed_bcd_conv_v_if #(.W_IN(9), .N_DIG(3)) bus ();

    signed_bcd_conv_v #(.W_IN(9), .N_DIG(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret the low 9 bits as signed, then split |v| into decimal digits.
    task automatic model(input int v, output logic s, output logic [11:0] b);
        int w;
        int m;
        w = v & 511;
        if (w >= 256) w = w - 512;
        s = (w < 0);
        m = (w < 0) ? -w : w;
        b = {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endtask

    // Called at a negedge with the block idle; returns at the negedge after the accept edge.
    task automatic start(input int v, input bit keep_valid);
        chk("ready_before_accept", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_fs    = 9'(v);
        @(negedge clk);
        if (!keep_valid) bus.i_valid = 1'b0;
    endtask

    // Waits for the o_valid pulse, checking latency, ready-low span, output hold and result.
    task automatic finish_conv(input int v, input string tag);
        logic        es;
        logic [11:0] eb;
        int          lat;
        int          low;
        bit          held;
        lat  = 0;
        low  = 0;
        held = 1'b1;
        model(v, es, eb);
        while (bus.o_valid !== 1'b1 && lat < 20) begin
            if (bus.o_ready === 1'b0) low++;
            if (bus.o_sign !== last_s || bus.o_bcd !== last_b) held = 1'b0;
            lat++;
            @(negedge clk);
        end
        chk({tag, "_valid_seen"}, 32'(bus.o_valid), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_ready_low"}, 32'(low), 32'd9);
        chk({tag, "_hold"}, 32'(held), 32'd1);
        chk({tag, "_sign"}, 32'(bus.o_sign), 32'(es));
        chk({tag, "_bcd"}, 32'(bus.o_bcd), 32'(eb));
        chk({tag, "_ready_at_valid"}, 32'(bus.o_ready), 32'd1);
        $display("[TB] %s: in=%0d fs=%03h sign=%0b bcd=%03h exp_sign=%0b exp_bcd=%03h latency=%0d",
                 tag, v, 9'(v), bus.o_sign, bus.o_bcd, es, eb, lat);
        last_s = es;
        last_b = eb;
    endtask

    // Next negedge: pulse must be over and results must still be held.
    task automatic pulse_end(input string tag);
        @(negedge clk);
        chk({tag, "_pulse_width"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_sign_held"}, 32'(bus.o_sign), 32'(last_s));
        chk({tag, "_bcd_held"}, 32'(bus.o_bcd), 32'(last_b));
    endtask

    task automatic convert(input int v, input string tag);
        start(v, 1'b0);
        finish_conv(v, tag);
        pulse_end(tag);
    endtask

    initial begin
        int r;
        int v;
        int seen;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_fs    = '0;
        last_s      = 1'b0;
        last_b      = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_sign", 32'(bus.o_sign), 32'd0);
        chk("rst_bcd", 32'(bus.o_bcd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(0, "zero");
        convert(255, "max_pos");
        convert(-256, "most_neg");
        convert(-1, "minus_one");
        convert(-165, "calc_x0_y15");
        convert(266, "calc_wrap_266");

        // Back-to-back: i_valid held high, second value accepted during the o_valid cycle.
        start(37, 1'b1);
        finish_conv(37, "b2b_first");
        t_first  = $realtime;
        bus.i_fs = 9'(-90);
        pulse_end("b2b_first");
        bus.i_valid = 1'b0;
        finish_conv(-90, "b2b_second");
        t_second = $realtime;
        chk("b2b_spacing_cycles", 32'(int'((t_second - t_first) / 10.0)), 32'd10);
        pulse_end("b2b_second");

        // Reset during the conversion of 123.
        start(123, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.o_ready), 32'd1);
        chk("abort_valid", 32'(bus.o_valid), 32'd0);
        chk("abort_sign", 32'(bus.o_sign), 32'd0);
        chk("abort_bcd", 32'(bus.o_bcd), 32'd0);
        $display("[TB] abort: reset during conversion of 123");
        last_s = 1'b0;
        last_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        convert(42, "after_abort");

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 511));
            v = (r >= 256) ? r - 512 : r;
            convert(v, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
